// File: rtl/inst_package.sv
// Shared types and widths for the write-back stage of the dual-issue pipeline.
package inst_package;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int INSTRET_W  = 64;

    // One register-file write port as seen by the register file and the
    // forwarding network.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_port_t;

    // Per-slot fields carried out of the memory stage.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rt;
        logic                  rt_flag;
        logic                  is_load;
        logic [DATA_W-1:0]     alu_result;
    } wb_slot_t;

endpackage : inst_package

// File: rtl/write_back_slot_sel.sv
// Per-slot write qualification and result select. Purely combinational.
module wb_slot_sel
    import inst_package::*;
(
    input  wb_slot_t          i_slot,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_data
);

    // Qualify the write (register 0 is hard-wired) and pick load data or ALU result.
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        o_wr   = i_slot.valid & i_slot.rt_flag & (i_slot.rt != '0);
        o_data = i_slot.is_load ? i_mem_dout : i_slot.alu_result;
    end

endmodule : wb_slot_sel

// File: rtl/write_back.sv
// Write-back stage: registers the bundle leaving the memory stage, drives the
// two register-file write ports (lower slot wins same-register conflicts)
// and counts retired instructions.
module write_back #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int INSTRET_W  = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  interlock,
    input  logic [31:0]           pc,
    input  logic                  u_valid,
    input  logic                  l_valid,
    input  logic [REG_ADDR_W-1:0] u_rt,
    input  logic [REG_ADDR_W-1:0] l_rt,
    input  logic                  u_rt_flag,
    input  logic                  l_rt_flag,
    input  logic                  u_is_load,
    input  logic                  l_is_load,
    input  logic [DATA_W-1:0]     u_alu_result,
    input  logic [DATA_W-1:0]     l_alu_result,
    input  logic [DATA_W-1:0]     mem_douta,
    input  logic [DATA_W-1:0]     mem_doutb,
    output logic                  u_we,
    output logic                  l_we,
    output logic [REG_ADDR_W-1:0] u_waddr,
    output logic [REG_ADDR_W-1:0] l_waddr,
    output logic [DATA_W-1:0]     u_wdata,
    output logic [DATA_W-1:0]     l_wdata,
    output logic [31:0]           retired_pc,
    output logic [INSTRET_W-1:0]  instret
);

    inst_package::wb_slot_t w_u_slot;
    inst_package::wb_slot_t w_l_slot;
    logic                   w_u_wr;
    logic                   w_l_wr;
    logic [DATA_W-1:0]      w_u_data;
    logic [DATA_W-1:0]      w_l_data;

    // Stage registers.
    logic [31:0]            r_pc;
    logic                   r_u_wr;
    logic                   r_l_wr;
    logic [REG_ADDR_W-1:0]  r_u_rt;
    logic [REG_ADDR_W-1:0]  r_l_rt;
    logic [DATA_W-1:0]      r_u_data;
    logic [DATA_W-1:0]      r_l_data;
    logic                   r_fresh;
    logic [INSTRET_W-1:0]   r_instret;

    inst_package::wb_port_t w_u_port;
    inst_package::wb_port_t w_l_port;
    logic                   w_conflict;
    logic [INSTRET_W-1:0]   w_retire_cnt;

    // Pack the incoming slot fields for the selectors.
    always_comb begin
        w_u_slot            = '0;
        w_u_slot.valid      = u_valid;
        w_u_slot.rt         = u_rt;
        w_u_slot.rt_flag    = u_rt_flag;
        w_u_slot.is_load    = u_is_load;
        w_u_slot.alu_result = u_alu_result;

        w_l_slot            = '0;
        w_l_slot.valid      = l_valid;
        w_l_slot.rt         = l_rt;
        w_l_slot.rt_flag    = l_rt_flag;
        w_l_slot.is_load    = l_is_load;
        w_l_slot.alu_result = l_alu_result;
    end

    wb_slot_sel u_slot_sel (
        .i_slot     (w_u_slot),
        .i_mem_dout (mem_douta),
        .o_wr       (w_u_wr),
        .o_data     (w_u_data)
    );

    wb_slot_sel l_slot_sel (
        .i_slot     (w_l_slot),
        .i_mem_dout (mem_doutb),
        .o_wr       (w_l_wr),
        .o_data     (w_l_data)
    );

    // Number of instructions retiring with this bundle: 0, 1 or 2.
    assign w_retire_cnt = INSTRET_W'(u_valid) + INSTRET_W'(l_valid);

    // Capture the bundle when not interlocked; fresh marks a bundle not yet written.
    // NOTE: rstn is sampled only at the clock edge (synchronous reset), and the
    // stage registers are plain flops, so clearing them all here is cheap.
    // Sequential state uses non-blocking assignments so every flop sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc      <= '0;
            r_u_wr    <= 1'b0;
            r_l_wr    <= 1'b0;
            r_u_rt    <= '0;
            r_l_rt    <= '0;
            r_u_data  <= '0;
            r_l_data  <= '0;
            r_fresh   <= 1'b0;
            r_instret <= '0;
        end else if (!interlock) begin
            r_pc      <= pc;
            r_u_wr    <= w_u_wr;
            r_l_wr    <= w_l_wr;
            r_u_rt    <= u_rt;
            r_l_rt    <= l_rt;
            r_u_data  <= w_u_data;
            r_l_data  <= w_l_data;
            r_fresh   <= 1'b1;
            r_instret <= r_instret + w_retire_cnt;
        end else begin
            r_fresh   <= 1'b0;
        end
    end

    // Lower slot is younger in program order, so it owns a shared destination.
    assign w_conflict = r_l_wr & (r_l_rt == r_u_rt);

    // Build the two write ports from the stage registers.
    always_comb begin
        w_u_port      = '0;
        w_u_port.we   = r_fresh & r_u_wr & ~w_conflict;
        w_u_port.addr = r_u_rt;
        w_u_port.data = r_u_data;

        w_l_port      = '0;
        w_l_port.we   = r_fresh & r_l_wr;
        w_l_port.addr = r_l_rt;
        w_l_port.data = r_l_data;
    end

    assign u_we       = w_u_port.we;
    assign u_waddr    = w_u_port.addr;
    assign u_wdata    = w_u_port.data;
    assign l_we       = w_l_port.we;
    assign l_waddr    = w_l_port.addr;
    assign l_wdata    = w_l_port.data;
    assign retired_pc = r_pc;
    assign instret    = r_instret;

endmodule : write_back

// File: tb/tb_write_back.sv
// Bench for write_back: directed test-plan steps followed by a random phase,
// all checked against a bundle-level reference model. A second instance with
// a 2-bit instret exercises counter wrap-around on the same stimulus.
module tb_write_back;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, interlock;
    logic [31:0] pc;
    logic        u_valid, l_valid, u_rt_flag, l_rt_flag, u_is_load, l_is_load;
    logic [4:0]  u_rt, l_rt;
    logic [31:0] u_alu_result, l_alu_result, mem_douta, mem_doutb;

    logic        u_we, l_we;
    logic [4:0]  u_waddr, l_waddr;
    logic [31:0] u_wdata, l_wdata, retired_pc;
    logic [63:0] instret;

    logic        u_we_w, l_we_w;
    logic [4:0]  u_waddr_w, l_waddr_w;
    logic [31:0] u_wdata_w, l_wdata_w, retired_pc_w;
    logic [1:0]  instret_w;

    write_back dut (
        .clk(clk), .rstn(rstn), .interlock(interlock), .pc(pc),
        .u_valid(u_valid), .l_valid(l_valid), .u_rt(u_rt), .l_rt(l_rt),
        .u_rt_flag(u_rt_flag), .l_rt_flag(l_rt_flag),
        .u_is_load(u_is_load), .l_is_load(l_is_load),
        .u_alu_result(u_alu_result), .l_alu_result(l_alu_result),
        .mem_douta(mem_douta), .mem_doutb(mem_doutb),
        .u_we(u_we), .l_we(l_we), .u_waddr(u_waddr), .l_waddr(l_waddr),
        .u_wdata(u_wdata), .l_wdata(l_wdata),
        .retired_pc(retired_pc), .instret(instret)
    );

    write_back #(.INSTRET_W(2)) dut_w (
        .clk(clk), .rstn(rstn), .interlock(interlock), .pc(pc),
        .u_valid(u_valid), .l_valid(l_valid), .u_rt(u_rt), .l_rt(l_rt),
        .u_rt_flag(u_rt_flag), .l_rt_flag(l_rt_flag),
        .u_is_load(u_is_load), .l_is_load(l_is_load),
        .u_alu_result(u_alu_result), .l_alu_result(l_alu_result),
        .mem_douta(mem_douta), .mem_doutb(mem_doutb),
        .u_we(u_we_w), .l_we(l_we_w), .u_waddr(u_waddr_w), .l_waddr(l_waddr_w),
        .u_wdata(u_wdata_w), .l_wdata(l_wdata_w),
        .retired_pc(retired_pc_w), .instret(instret_w)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the last captured bundle, whether it still owes its
    // write, and the retirement count.
    logic        m_pending;
    logic        m_u_wr, m_l_wr;
    logic [4:0]  m_u_rt, m_l_rt;
    logic [31:0] m_u_data, m_l_data, m_pc;
    logic [63:0] m_instret;
    int          m_instret_small;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic [4:0] urt, input logic uf, input logic ul,
                         input logic [31:0] ua, input logic lv, input logic [4:0] lrt,
                         input logic lf, input logic ll, input logic [31:0] la,
                         input logic [31:0] ma, input logic [31:0] mb, input logic il);
        u_valid = uv; u_rt = urt; u_rt_flag = uf; u_is_load = ul; u_alu_result = ua;
        l_valid = lv; l_rt = lrt; l_rt_flag = lf; l_is_load = ll; l_alu_result = la;
        mem_douta = ma; mem_doutb = mb; interlock = il;
        pc = $urandom();
    endtask

    // What the coming clock edge does to the bundle state.
    task automatic model_edge();
        if (!rstn) begin
            m_pending = 0; m_u_wr = 0; m_l_wr = 0; m_u_rt = 0; m_l_rt = 0;
            m_u_data = 0; m_l_data = 0; m_pc = 0; m_instret = 0; m_instret_small = 0;
        end else if (!interlock) begin
            m_pending = 1;
            m_pc      = pc;
            m_u_wr    = u_valid && u_rt_flag && (u_rt != 0);
            m_l_wr    = l_valid && l_rt_flag && (l_rt != 0);
            m_u_rt    = u_rt;
            m_l_rt    = l_rt;
            m_u_data  = u_is_load ? mem_douta : u_alu_result;
            m_l_data  = l_is_load ? mem_doutb : l_alu_result;
            m_instret = m_instret + 64'(int'(u_valid) + int'(l_valid));
            m_instret_small = (m_instret_small + int'(u_valid) + int'(l_valid)) % 4;
        end else begin
            m_pending = 0;
        end
    endtask

    task automatic check_all();
        logic exp_u_we, exp_l_we;
        exp_l_we = m_pending && m_l_wr;
        exp_u_we = m_pending && m_u_wr && !(m_l_wr && m_l_rt == m_u_rt);
        check("u_we",       64'(u_we),     64'(exp_u_we));
        check("l_we",       64'(l_we),     64'(exp_l_we));
        check("u_waddr",    64'(u_waddr),  64'(m_u_rt));
        check("l_waddr",    64'(l_waddr),  64'(m_l_rt));
        check("u_wdata",    64'(u_wdata),  64'(m_u_data));
        check("l_wdata",    64'(l_wdata),  64'(m_l_data));
        check("retired_pc", 64'(retired_pc), 64'(m_pc));
        check("instret",    instret,       m_instret);
        check("instret_wrap", 64'(instret_w), 64'(m_instret_small));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] base;
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_u_we", 64'(u_we), 64'd0);
        check("reset_instret", instret, 64'd0);

        // Single ALU op into r3.
        @(negedge clk);
        rstn = 1'b1;
        drive(1, 5'd3, 1, 0, 32'h0000_00AA, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        tick();
        check("alu_u_we", 64'(u_we), 64'd1);
        check("alu_u_wdata", 64'(u_wdata), 64'h0000_00AA);
        check("alu_instret", instret, 64'd1);

        // Dual load.
        drive(1, 5'd4, 1, 1, 32'h1111_1111, 1, 5'd5, 1, 1, 32'h2222_2222,
              32'h1234_5678, 32'hDEAD_BEEF, 0);
        tick();
        check("load_u_wdata", 64'(u_wdata), 64'h1234_5678);
        check("load_l_wdata", 64'(l_wdata), 64'hDEAD_BEEF);
        check("load_instret", instret, 64'd3);

        // Same destination: lower slot wins.
        drive(1, 5'd7, 1, 0, 32'd1, 1, 5'd7, 1, 0, 32'd2, 0, 0, 0);
        tick();
        check("conf_u_we", 64'(u_we), 64'd0);
        check("conf_l_we", 64'(l_we), 64'd1);
        check("conf_l_wdata", 64'(l_wdata), 64'd2);
        check("conf_instret", instret, 64'd5);

        // Capture r9, then hold for three cycles with garbage on the inputs.
        drive(1, 5'd9, 1, 0, 32'hCAFE_0009, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("hold0_u_we", 64'(u_we), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'($urandom()), 1, 0, $urandom(), 1, 5'($urandom()), 1, 0, $urandom(),
                  $urandom(), $urandom(), 1);
            tick();
            check("hold_u_we", 64'(u_we), 64'd0);
            check("hold_u_waddr", 64'(u_waddr), 64'd9);
            check("hold_u_wdata", 64'(u_wdata), 64'hCAFE_0009);
            check("hold_instret", instret, 64'd6);
        end

        // r0 destination and a bubble.
        drive(1, 5'd0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("r0_u_we", 64'(u_we), 64'd0);
        check("r0_instret", instret, 64'd7);
        drive(0, 5'd6, 1, 0, 32'h66, 0, 5'd8, 1, 0, 32'h88, 0, 0, 0);
        tick();
        check("bubble_l_we", 64'(l_we), 64'd0);
        check("bubble_instret", instret, 64'd7);

        // Random phase: small register range to provoke conflicts and r0.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom()), 5'($urandom_range(0, 7)), 1'($urandom()), 1'($urandom()),
                  $urandom(), 1'($urandom()), 5'($urandom_range(0, 7)), 1'($urandom()),
                  1'($urandom()), $urandom(), $urandom(), $urandom(),
                  ($urandom_range(0, 3) == 0));
            rstn = ($urandom_range(0, 49) != 0);
            tick();
        end
        rstn = 1'b1;

        // Reset arriving during an interlock clears everything at that edge.
        drive(1, 5'd12, 1, 0, 32'h1200, 1, 5'd13, 1, 0, 32'h1300, 0, 0, 0);
        tick();
        base = instret;
        drive(1, 5'd14, 1, 0, 32'h1400, 1, 5'd15, 1, 0, 32'h1500, 0, 0, 1);
        tick();
        check("il_instret", instret, base);
        rstn = 1'b0;
        tick();
        check("rst_il_l_waddr", 64'(l_waddr), 64'd0);
        check("rst_il_instret", instret, 64'd0);

        // Reset and capture on the same edge: reset wins.
        interlock = 1'b0;
        tick();
        check("rst_cap_l_we", 64'(l_we), 64'd0);
        rstn = 1'b1;
        tick();
        check("after_rst_instret", instret, 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_write_back
